// File: rtl/imem_loader.sv
// Boot loader: packs a valid/ready byte stream big-endian into 32-bit words and writes them into the
// instruction ROM, holding the core in reset until the load completes. Optional checksum: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_start,
    input  logic [ADDR_WIDTH:0]   i_word_count,
    input  logic                  i_byte_valid,
    input  logic [7:0]            i_byte_data,
    output logic                  o_byte_ready,
    output logic                  o_imem_we,
    output logic [ADDR_WIDTH-1:0] o_imem_addr,
    output logic [31:0]           o_imem_wdata,
    output logic                  o_core_rst_n,
    output logic                  o_busy,
    output logic                  o_done,
    output logic                  o_err
);

    localparam logic [ADDR_WIDTH:0] MAX_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] ONE_COUNT = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4,
        ST_CHECK   = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_DONE    = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;
`endif

    state_t                state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [ADDR_WIDTH:0]   count_reg, count_next;
    logic [1:0]            byte_cnt_reg, byte_cnt_next;
    logic [31:0]           word_reg, word_next;
    logic                  first_reg, first_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]            sum_reg, sum_next;
`endif

    logic count_bad;
    logic last_word;

    assign count_bad = (i_word_count == '0) || (i_word_count > MAX_COUNT);
    assign last_word = ({1'b0, addr_reg} == (count_reg - ONE_COUNT));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg    <= ST_IDLE;
            addr_reg     <= '0;
            count_reg    <= '0;
            byte_cnt_reg <= '0;
            word_reg     <= '0;
            first_reg    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            addr_reg     <= addr_next;
            count_reg    <= count_next;
            byte_cnt_reg <= byte_cnt_next;
            word_reg     <= word_next;
            first_reg    <= first_next;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_reg      <= sum_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        addr_next     = addr_reg;
        count_next    = count_reg;
        byte_cnt_next = byte_cnt_reg;
        word_next     = word_reg;
        first_next    = first_reg;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_next      = sum_reg;
`endif
        case (state_reg)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (i_start) begin
                    if (count_bad) begin
                        state_next = ST_ERROR;
                    end else begin
                        state_next    = ST_COLLECT;
                        count_next    = i_word_count;
                        addr_next     = '0;
                        byte_cnt_next = '0;
                        first_next    = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                        sum_next      = '0;
`endif
                    end
                end
            end
            ST_COLLECT: begin
                if (i_byte_valid) begin
                    word_next     = {word_reg[23:0], i_byte_data};
                    byte_cnt_next = byte_cnt_reg + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_next      = sum_reg + i_byte_data;
`endif
                    if (byte_cnt_reg == 2'd3) begin
                        // Address advances as the next word completes, so it keeps the last written value between writes.
                        state_next = ST_WRITE;
                        first_next = 1'b0;
                        if (!first_reg) begin
                            addr_next = addr_reg + 1'b1;
                        end
                    end
                end
            end
            ST_WRITE: begin
                if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = ST_CHECK;
`else
                    state_next = ST_DONE;
`endif
                end else begin
                    state_next = ST_COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (i_byte_valid) begin
                    state_next = (i_byte_data == sum_reg) ? ST_DONE : ST_ERROR;
                end
            end
`endif
            default: state_next = ST_IDLE;
        endcase
    end

    // Every output decodes from state or comes straight from a register.
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign o_byte_ready = (state_reg == ST_COLLECT) || (state_reg == ST_CHECK);
    assign o_busy       = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE) || (state_reg == ST_CHECK);
`else
    assign o_byte_ready = (state_reg == ST_COLLECT);
    assign o_busy       = (state_reg == ST_COLLECT) || (state_reg == ST_WRITE);
`endif
    assign o_imem_we    = (state_reg == ST_WRITE);
    assign o_imem_addr  = addr_reg;
    assign o_imem_wdata = word_reg;
    assign o_core_rst_n = (state_reg == ST_DONE);
    assign o_done       = (state_reg == ST_DONE);
    assign o_err        = (state_reg == ST_ERROR);

endmodule
